// File: rtl/rr_mask_ctrl.sv
`timescale 1ns/1ps
// rr_mask_ctrl: control stage around the external 4-way fixed-priority encoder
// of the round-robin arbiter. It masks requests with the last-grant pointer,
// fires the encoder, captures the one-hot result, and holds the grant until
// release or hold timeout.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no grant; fire encoder (pl_en) as soon as any req is high
//   ARB   | encoder result arriving; capture if one-hot, else flag err
//   GRANT | grant held; count tenure; drop on release or timeout
module rr_mask_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic               pl_en,
  output logic [NUM_REQ-1:0] pl_req,
  input  logic [NUM_REQ-1:0] pl_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic               forced_rel,
  output logic               err
);

  localparam int         PTR_W      = $clog2(NUM_REQ);
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam bit         HOLD_EN    = (MAX_HOLD != 0);

  if (NUM_REQ != 4) begin : g_bad_num_req
    $error("rr_mask_ctrl: only NUM_REQ = 4 is supported");
  end
  if (MAX_HOLD < 0 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_mask_ctrl: MAX_HOLD must be in 0..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic               forced_rel_q, forced_rel_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] req_masked;
  logic               grant_onehot;
  logic [PTR_W-1:0]   gnt_idx;
  logic               release_hit;
  logic               timeout_hit;

  // Mask keeps only requesters strictly above the last winner.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i > int'(ptr_q));
    end
  end

  // Fall back to the raw vector when nobody above the pointer is asking,
  // which gives the wrap-around back to the low indices.
  always_comb begin
    req_masked = req & mask;
    pl_req     = (req_masked != '0) ? req_masked : req;
  end

  // Encoder output must carry exactly one bit to be accepted.
  always_comb begin
    grant_onehot = (pl_grant != '0) &&
                   ((pl_grant & (pl_grant - NUM_REQ'(1))) == '0);
  end

  // Index of the held grant, used to advance the pointer on exit.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) gnt_idx = PTR_W'(i);
    end
  end

  // Exit conditions while granted; release wins over a coincident timeout.
  always_comb begin
    release_hit = ((req & gnt_q) == '0);
    timeout_hit = HOLD_EN && (hold_cnt_q == HOLD_LIMIT);
  end

  // Next-state, encoder enable and datapath updates.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    ptr_d        = ptr_q;
    hold_cnt_d   = hold_cnt_q;
    forced_rel_d = 1'b0;
    err_d        = err_q;
    pl_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          pl_en   = 1'b1;
          state_d = ARB;
        end
      end

      ARB: begin
        if (grant_onehot) begin
          gnt_d      = pl_grant;
          hold_cnt_d = 8'd1;
          state_d    = GRANT;
        end else begin
          err_d   = 1'b1;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end

      GRANT: begin
        if (hold_cnt_q != 8'hFF) hold_cnt_d = hold_cnt_q + 8'd1;
        if (release_hit || timeout_hit) begin
          gnt_d        = '0;
          ptr_d        = gnt_idx;
          hold_cnt_d   = '0;
          forced_rel_d = !release_hit;
          state_d      = IDLE;
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      ptr_q        <= PTR_W'(NUM_REQ - 1);
      hold_cnt_q   <= '0;
      forced_rel_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      ptr_q        <= ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      forced_rel_q <= forced_rel_d;
      err_q        <= err_d;
    end
  end

  // Outputs come straight from flops so gnt and forced_rel change together.
  always_comb begin
    gnt        = gnt_q;
    gnt_valid  = |gnt_q;
    forced_rel = forced_rel_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_rr_mask_ctrl.sv
`timescale 1ns/1ps
// Bench for rr_mask_ctrl: a fixed-priority encoder model feeds pl_grant,
// expected grants are queued as requests are driven and popped when gnt rises.
module tb_rr_mask_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, pl_req, pl_grant, gnt, enc_q;
  logic       pl_en, gnt_valid, forced_rel, err;
  logic       ovr_en;
  logic [3:0] ovr_val;

  logic [3:0] req_t, pl_req_t, pl_grant_t, gnt_t, enc_t_q;
  logic       pl_en_t, gnt_valid_t, forced_rel_t, err_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] prev_gnt = 4'b0;

  always #5 clk = ~clk;

  rr_mask_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pl_en(pl_en), .pl_req(pl_req),
    .pl_grant(pl_grant), .gnt(gnt), .gnt_valid(gnt_valid),
    .forced_rel(forced_rel), .err(err)
  );

  rr_mask_ctrl #(.NUM_REQ(4), .MAX_HOLD(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .req(req_t), .pl_en(pl_en_t), .pl_req(pl_req_t),
    .pl_grant(pl_grant_t), .gnt(gnt_t), .gnt_valid(gnt_valid_t),
    .forced_rel(forced_rel_t), .err(err_t)
  );

  function automatic logic [3:0] prio(input logic [3:0] r);
    logic [3:0] g;
    g = 4'b0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) begin
        g = 4'b0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction

  // Registered fixed-priority encoders, bit 0 highest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_q   <= 4'b0;
      enc_t_q <= 4'b0;
    end else begin
      enc_q   <= pl_en   ? prio(pl_req)   : 4'b0;
      enc_t_q <= pl_en_t ? prio(pl_req_t) : 4'b0;
    end
  end

  assign pl_grant   = ovr_en ? ovr_val : enc_q;
  assign pl_grant_t = enc_t_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit use_to);
    int n = 0;
    while (((use_to ? gnt_t : gnt) == 4'b0) && n < 10) begin
      cyc();
      n++;
    end
    if ((use_to ? gnt_t : gnt) == 4'b0)
      chk("wait_gnt", 32'(use_to ? gnt_valid_t : gnt_valid), 32'd1);
  endtask

  // Scoreboard: every new grant on the main instance must match the queue head.
  always @(negedge clk) begin
    if (rst_n && gnt != 4'b0 && prev_gnt == 4'b0) begin
      chk("sb_gnt_valid", 32'(gnt_valid), 32'd1);
      if (exp_q.size() == 0) chk("sb_unexpected", 32'(gnt), 32'd0);
      else chk("sb_gnt", 32'(gnt), 32'(exp_q.pop_front()));
    end
    prev_gnt = gnt;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rot [6];
    int hi;
    rot[0] = 4'b1000; rot[1] = 4'b0001; rot[2] = 4'b0010;
    rot[3] = 4'b0100; rot[4] = 4'b1000; rot[5] = 4'b0001;

    rst_n = 1'b0; req = 4'b0; req_t = 4'b0; ovr_en = 1'b0; ovr_val = 4'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
    chk("rst_pl_en", 32'(pl_en), 32'd0);
    chk("rst_pl_req", 32'(pl_req), 32'd0);
    chk("rst_forced_rel", 32'(forced_rel), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Single request latency and release.
    cyc();
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    #1;
    chk("single_pl_en", 32'(pl_en), 32'd1);
    chk("single_pl_req", 32'(pl_req), 32'b0100);
    cyc();
    chk("single_arb_gnt", 32'(gnt), 32'd0);
    chk("single_arb_pl_en", 32'(pl_en), 32'd0);
    cyc();
    chk("single_gnt_c2", 32'(gnt), 32'b0100);
    repeat (4) cyc();
    chk("single_gnt_c6", 32'(gnt), 32'b0100);
    req = 4'b0;
    cyc();
    chk("single_rel_gnt", 32'(gnt), 32'd0);
    chk("single_rel_frel", 32'(forced_rel), 32'd0);

    // Rotation with all requesters active; ptr=2 makes 3 first.
    for (int k = 0; k < 6; k++) begin
      req = 4'b1111;
      exp_q.push_back(rot[k]);
      if (k == 0) begin
        #1 chk("rot_ptr2_mask", 32'(pl_req), 32'b1000);
      end
      wait_gnt(1'b0);
      cyc();
      req = req & ~gnt;
      cyc();
      chk("rot_rel_gnt", 32'(gnt), 32'd0);
    end
    req = 4'b0;

    // Mask wrap: ptr=0 then ptr=3 with req=1001.
    cyc();
    req = 4'b1001;
    exp_q.push_back(4'b1000);
    #1 chk("wrap_ptr0_pl_req", 32'(pl_req), 32'b1000);
    wait_gnt(1'b0);
    cyc();
    req = 4'b0001;
    cyc();
    chk("wrap_rel_gnt", 32'(gnt), 32'd0);
    req = 4'b1001;
    exp_q.push_back(4'b0001);
    #1 chk("wrap_ptr3_pl_req", 32'(pl_req), 32'b1001);
    wait_gnt(1'b0);
    cyc();
    req = 4'b1000;
    cyc();
    req = 4'b0;

    // Error path: malformed encoder result.
    cyc();
    ovr_en = 1'b1; ovr_val = 4'b0110;
    req = 4'b0100;
    cyc();
    req = 4'b0;
    cyc();
    chk("err_set", 32'(err), 32'd1);
    chk("err_gnt", 32'(gnt), 32'd0);
    req = 4'b1111;
    #1;
    chk("err_back_idle", 32'(pl_en), 32'd1);
    chk("err_ptr_kept", 32'(pl_req), 32'b1110);
    cyc();
    req = 4'b0;
    cyc();
    ovr_en = 1'b0;
    repeat (3) cyc();
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_no_gnt", 32'(gnt), 32'd0);

    // Asynchronous reset while granted.
    req = 4'b1000;
    exp_q.push_back(4'b1000);
    wait_gnt(1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_gnt_valid", 32'(gnt_valid), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    req = 4'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    req = 4'b1000;
    exp_q.push_back(4'b1000);
    cyc();
    chk("arst_c1_gnt", 32'(gnt), 32'd0);
    cyc();
    chk("arst_c2_gnt", 32'(gnt), 32'b1000);
    cyc();
    req = 4'b0;
    cyc();

    // Timeout with MAX_HOLD=4 on the second instance.
    req_t = 4'b1010;
    wait_gnt(1'b1);
    chk("to_first", 32'(gnt_t), 32'b0010);
    hi = 0;
    while (gnt_t == 4'b0010 && hi < 20) begin
      hi++;
      cyc();
    end
    chk("to_tenure", 32'(hi), 32'd4);
    chk("to_gnt_fall", 32'(gnt_t), 32'd0);
    chk("to_frel_on", 32'(forced_rel_t), 32'd1);
    cyc();
    chk("to_frel_off", 32'(forced_rel_t), 32'd0);
    wait_gnt(1'b1);
    chk("to_next", 32'(gnt_t), 32'b1000);
    req_t = 4'b0;
    cyc();
    cyc();

    // Release on the same cycle the hold limit is reached.
    req_t = 4'b0010;
    wait_gnt(1'b1);
    chk("rt_gnt", 32'(gnt_t), 32'b0010);
    repeat (3) cyc();
    chk("rt_still_held", 32'(gnt_t), 32'b0010);
    req_t = 4'b0;
    cyc();
    chk("rt_gnt_drop", 32'(gnt_t), 32'd0);
    chk("rt_no_frel", 32'(forced_rel_t), 32'd0);
    chk("to_err_clear", 32'(err_t), 32'd0);

    cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_mask_ctrl.md
Name: rr_mask_ctrl

Overview:
- Control stage wrapped around the 4-way fixed-priority encoder (bit 0 highest) of the round-robin arbiter.
- Upstream: masks the raw request vector with a rotating last-grant pointer, then pulses the encoder enable.
- Downstream: captures the encoder's registered one-hot result and drives the requester grant.
- Holds each grant until the requester releases it or a hold timeout expires; this gives fair rotation and bounded tenure.

Parameters:
- NUM_REQ, 4, number of requesters; must match the encoder width; only 4 is supported.
- MAX_HOLD, 16, maximum grant tenure in cycles, range 1..255; 0 means unlimited tenure.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  raw request vector; requester i holds req[i] high while it wants or owns the resource.
- pl_en  output  1  enable to the encoder.
- pl_req  output  NUM_REQ  masked or raw request vector to the encoder.
- pl_grant  input  NUM_REQ  registered one-hot output of the encoder; valid 1 cycle after pl_en is sampled high.
- gnt  output  NUM_REQ  one-hot grant to requesters; all zeros when the resource is idle.
- gnt_valid  output  1  high whenever gnt is non-zero.
- forced_rel  output  1  one-cycle pulse when a grant is revoked by timeout.
- err  output  1  sticky; set if pl_grant is zero or not one-hot at capture; cleared only by reset.

Behaviour:
- Reset values: gnt=0, gnt_valid=0, pl_en=0, pl_req=0, forced_rel=0, err=0, ptr=NUM_REQ-1 (so requester 0 wins first), hold_cnt=0, state=IDLE.
- pl_req = req & mask when (req & mask) is non-zero, else pl_req = req. The mask bit i = 1 iff i > ptr (strictly higher index than the last grant). This gives lowest index above the last winner first, then wrap-around.
- pl_req is combinational from req and ptr. pl_en is combinational: 1 only in IDLE with |req=1.
- FSM states:
  - IDLE: if |req, then pl_en=1 and next state is ARB; otherwise stay in IDLE.
  - ARB: pl_en=0. If pl_grant is one-hot, latch gnt<=pl_grant, reset hold_cnt to 1, next state GRANT. Otherwise set err, gnt stays 0, return to IDLE.
  - GRANT: gnt held constant; hold_cnt increments each cycle, saturating at 255.
    - Release condition: (req & gnt)==0.
    - Timeout condition: MAX_HOLD!=0 and hold_cnt==MAX_HOLD while req still held.
    - On either condition: gnt<=0, ptr<=index of the granted bit, next state IDLE. On timeout also pulse forced_rel for 1 cycle, coincident with gnt falling.
- Latency: req rising in cycle 0 in IDLE gives pl_en=1 in cycle 0, pl_grant valid in cycle 1, gnt high in cycle 2.
- Every grant is followed by at least one IDLE cycle; back-to-back grants to different requesters are 3 cycles apart.
- Simultaneous events:
  - Requests that change during ARB do not alter the captured grant.
  - New requests arriving during GRANT wait for the next IDLE.
  - A release and a timeout in the same cycle are treated as a release: no forced_rel.
- Only a grant updates ptr; err cycles and idle cycles leave ptr unchanged.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); gnt drops in the same cycle.
- Re-arbitration after timeout: the revoked requester may keep req high, but the mask gives every other active requester precedence before it wins again.

Test Plan:
- Single request: after reset, req=4'b0100 → pl_en=1 with pl_req=4'b0100 in cycle 0; gnt=4'b0100 in cycle 2. Drop req at cycle 6 → gnt=0 at cycle 7, ptr=2.
- Rotation: req=4'b1111 held; each requester drops its req 1 cycle after being granted and re-raises 1 cycle later → grant order 0001,0010,0100,1000,0001 with no repeats within 4 grants.
- Mask wrap: ptr=3 (last grant to 3), req=4'b1001 → pl_req=4'b1001 (masked set empty), gnt=4'b0001. With ptr=0 and req=4'b1001 → pl_req=4'b1000, gnt=4'b1000.
- Timeout with MAX_HOLD=4: req=4'b0010 held forever alongside req[3] → gnt=0010 for exactly 4 cycles, forced_rel pulses once, next grant is 1000.
- Error path: force pl_grant=4'b0110 in ARB → err=1 and stays set, gnt stays 0, FSM returns to IDLE, ptr unchanged.
- Async reset during GRANT: assert rst_n low mid-cycle → gnt=0, gnt_valid=0, err=0 immediately. After release, req=4'b1000 → gnt=4'b1000 2 cycles after req.
